// File: rtl/stopwatch_pkg.sv
// Shared display constants for the stopwatch: BCD digit type, refresh
// default and active-low segment patterns ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    // 100 MHz clock / 100000 = 1 kHz per digit slot.
    localparam int REFRESH_100MHZ = 100000;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Capture inputs and display outputs of the 7-segment scan driver.
// master = producer/observer side, slave = the driver itself.
interface sevenseg_scan_driver_if #(
    parameter int N_DIGITS = 8
);
    logic                  enable;
    logic                  load;
    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output enable, load, digits_in, dp_in,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  enable, load, digits_in, dp_in,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    // Straight table lookup, codes 10..15 fall through to the dash.
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver. New data is staged in a
// pending register and only promoted to the display register at a frame
// boundary, so a single scan never mixes old and new digits.
module sevenseg_scan_driver
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = REFRESH_100MHZ,
    parameter int GUARD       = 16,
    parameter int BLANK_LZ    = 1
) (
    input logic                   clk,
    input logic                   rst,
    sevenseg_scan_driver_if.slave io
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    bcd_t [N_DIGITS-1:0]       pend_dig_q, pend_dig_d;
    bcd_t [N_DIGITS-1:0]       disp_dig_q, disp_dig_d;
    logic [N_DIGITS-1:0]       pend_dp_q, pend_dp_d;
    logic [N_DIGITS-1:0]       disp_dp_q, disp_dp_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [N_DIGITS-1:0]       an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      fd_q, fd_d;

    logic                      wrap;
    logic                      xfer;
    logic                      zero_run;
    logic [N_DIGITS-1:0]       lz;
    bcd_t                      cur_dig;
    logic [6:0]                cur_seg;

    // Slot counter and digit index; both parked at 0 while disabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        wrap  = 1'b0;
        if (!io.enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Capture into pending; promote old pending to display at the frame
    // boundary (or at once while dark). A coincident load re-arms pending.
    always_comb begin
        xfer       = pend_vld_q && (wrap || !io.enable);
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        disp_dig_d = disp_dig_q;
        disp_dp_d  = disp_dp_q;
        if (xfer) begin
            disp_dig_d = pend_dig_q;
            disp_dp_d  = pend_dp_q;
            pend_vld_d = 1'b0;
        end
        if (io.load) begin
            pend_dig_d = io.digits_in;
            pend_dp_d  = io.dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and everything above it
    // is a zero with no decimal point. Digit 0 always shows.
    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (disp_dig_q[i] == 4'd0) & ~disp_dp_q[i];
            lz[i]    = zero_run & (BLANK_LZ != 0);
        end
    end

    assign cur_dig = disp_dig_q[idx_q];

    bcd_to_7seg u_dec (
        .bcd_i (cur_dig),
        .seg_o (cur_seg)
    );

    // Next output values: anode held off for the guard window at slot start.
    always_comb begin
        an_d  = '1;
        seg_d = cur_seg;
        dp_d  = ~disp_dp_q[idx_q];
        fd_d  = wrap;
        if (io.enable && (cnt_q >= GUARD_C)) an_d[idx_q] = 1'b0;
        if (lz[idx_q]) begin
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
    end

    // State and registered outputs; async reset blanks the display at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_dig_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            disp_dig_q <= '0;
            disp_dp_q  <= '0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            disp_dig_q <= disp_dig_d;
            disp_dp_q  <= disp_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign io.an         = an_q;
    assign io.seg        = seg_q;
    assign io.dp         = dp_q;
    assign io.frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench: N_DIGITS=4, REFRESH_DIV=4, GUARD=1. Two instances run in
// lockstep, one with leading-zero blanking and one without.
module tb_sevenseg_scan_driver;

    localparam logic [6:0] T0 = 7'b1000000;
    localparam logic [6:0] T1 = 7'b1111001;
    localparam logic [6:0] T2 = 7'b0100100;
    localparam logic [6:0] T3 = 7'b0110000;
    localparam logic [6:0] T4 = 7'b0011001;
    localparam logic [6:0] T5 = 7'b0010010;
    localparam logic [6:0] T6 = 7'b0000010;
    localparam logic [6:0] T7 = 7'b1111000;
    localparam logic [6:0] T8 = 7'b0000000;
    localparam logic [6:0] T9 = 7'b0010000;
    localparam logic [6:0] TD = 7'b0111111;
    localparam logic [6:0] TX = 7'b1111111;

    // sa/sb are {digit3,digit2,digit1,digit0}; dpa/dpb are expected dp levels.
    typedef struct packed {
        logic [15:0]     dig;
        logic [3:0]      dpm;
        logic [3:0][6:0] sa;
        logic [3:0]      dpa;
        logic [3:0][6:0] sb;
        logic [3:0]      dpb;
    } vec_t;

    localparam int NAPPLY = 7;
    vec_t tv [11];

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic seen1;
    logic seen_other;

    sevenseg_scan_driver_if #(.N_DIGITS(4)) ifa ();
    sevenseg_scan_driver_if #(.N_DIGITS(4)) ifb ();

    assign ifb.enable    = ifa.enable;
    assign ifb.load      = ifa.load;
    assign ifb.digits_in = ifa.digits_in;
    assign ifb.dp_in     = ifa.dp_in;

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .BLANK_LZ(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .io  (ifa)
    );

    sevenseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .BLANK_LZ(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .io  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_load(input logic [15:0] d, input logic [3:0] m);
        ifa.digits_in = d;
        ifa.dp_in     = m;
        ifa.load      = 1'b1;
        tick();
        ifa.load      = 1'b0;
    endtask

    // Runs until frame_done, noting any '1' glyph or anything not from the
    // dark frame on the blanking instance.
    task automatic wait_fd(input string nm);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ifa.seg == T1) seen1 = 1'b1;
            if (ifa.seg != T0 && ifa.seg != TX) seen_other = 1'b1;
            if (ifa.frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_fd_seen"}, 32'(ok), 32'd1);
    endtask

    // Starts with counters at slot 0 count 0; checks one whole frame.
    task automatic check_slots(input vec_t v, input string nm);
        logic [3:0] ean;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                ean = (c == 0) ? 4'hF : ~(4'b0001 << s);
                chk($sformatf("%s_an_s%0d_c%0d", nm, s, c), 32'(ifa.an), 32'(ean));
                chk($sformatf("%s_segA_s%0d_c%0d", nm, s, c), 32'(ifa.seg), 32'(v.sa[s]));
                chk($sformatf("%s_dpA_s%0d_c%0d", nm, s, c), 32'(ifa.dp), 32'(v.dpa[s]));
                chk($sformatf("%s_segB_s%0d_c%0d", nm, s, c), 32'(ifb.seg), 32'(v.sb[s]));
                chk($sformatf("%s_dpB_s%0d_c%0d", nm, s, c), 32'(ifb.dp), 32'(v.dpb[s]));
                chk($sformatf("%s_fd_s%0d_c%0d", nm, s, c), 32'(ifa.frame_done),
                    32'((s == 3) && (c == 3)));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        seen1 = 1'b0;
        seen_other = 1'b0;

        tv[0]  = '{16'h1234, 4'b0100, {T1,T2,T3,T4}, 4'b1011, {T1,T2,T3,T4}, 4'b1011};
        tv[1]  = '{16'h0005, 4'b0000, {TX,TX,TX,T5}, 4'b1111, {T0,T0,T0,T5}, 4'b1111};
        tv[2]  = '{16'h00A0, 4'b0100, {TX,T0,TD,T0}, 4'b1011, {T0,T0,TD,T0}, 4'b1011};
        tv[3]  = '{16'h0000, 4'b0000, {TX,TX,TX,T0}, 4'b1111, {T0,T0,T0,T0}, 4'b1111};
        tv[4]  = '{16'h9876, 4'b1001, {T9,T8,T7,T6}, 4'b0110, {T9,T8,T7,T6}, 4'b0110};
        tv[5]  = '{16'hF0B0, 4'b0000, {TD,T0,TD,T0}, 4'b1111, {TD,T0,TD,T0}, 4'b1111};
        tv[6]  = '{16'h0300, 4'b0001, {TX,T3,T0,T0}, 4'b1110, {T0,T3,T0,T0}, 4'b1110};
        tv[7]  = '{16'h2222, 4'b0000, {T2,T2,T2,T2}, 4'b1111, {T2,T2,T2,T2}, 4'b1111};
        tv[8]  = '{16'h5555, 4'b0000, {T5,T5,T5,T5}, 4'b1111, {T5,T5,T5,T5}, 4'b1111};
        tv[9]  = '{16'h8888, 4'b0000, {T8,T8,T8,T8}, 4'b1111, {T8,T8,T8,T8}, 4'b1111};
        tv[10] = '{16'h0042, 4'b0000, {TX,TX,T4,T2}, 4'b1111, {T0,T0,T4,T2}, 4'b1111};

        rst           = 1'b0;
        ifa.enable    = 1'b1;
        ifa.load      = 1'b0;
        ifa.digits_in = '0;
        ifa.dp_in     = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_an", 32'(ifa.an), 32'hF);
        chk("rst_seg", 32'(ifa.seg), 32'h7F);
        chk("rst_dp", 32'(ifa.dp), 32'd1);
        chk("rst_fd", 32'(ifa.frame_done), 32'd0);
        #3 rst = 1'b1;
        check_slots(tv[3], "dark0");

        // Table: load, let the frame boundary promote it, check the next frame.
        for (int i = 0; i < NAPPLY; i++) begin
            apply_load(tv[i].dig, tv[i].dpm);
            wait_fd($sformatf("vec%0d", i));
            check_slots(tv[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle while digit 3 is lit.
        #3 rst = 1'b0;
        #1;
        chk("arst_an", 32'(ifa.an), 32'hF);
        chk("arst_seg", 32'(ifa.seg), 32'h7F);
        chk("arst_dp", 32'(ifa.dp), 32'd1);
        chk("arst_fd", 32'(ifa.frame_done), 32'd0);
        #2 rst = 1'b1;
        check_slots(tv[3], "dark1");

        // Tear-free: two loads mid-frame, only the latest shows next frame.
        tick();
        tick();
        tick();
        seen1 = 1'b0;
        seen_other = 1'b0;
        apply_load(16'h1111, 4'b0000);
        tick();
        apply_load(16'h2222, 4'b0000);
        wait_fd("tear");
        chk("tear_no_ones", 32'(seen1), 32'd0);
        chk("tear_old_frame", 32'(seen_other), 32'd0);
        check_slots(tv[7], "tear_new");

        // Load coincident with the wrap: old pending shown first.
        apply_load(16'h5555, 4'b0000);
        repeat (14) tick();
        apply_load(16'h8888, 4'b0000);
        chk("wrap_fd", 32'(ifa.frame_done), 32'd1);
        check_slots(tv[8], "wrap_old");
        check_slots(tv[9], "wrap_new");

        // Disable for 10 cycles mid-frame, load while dark, re-enable.
        repeat (5) tick();
        ifa.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                ifa.digits_in = 16'h0042;
                ifa.dp_in     = 4'b0000;
                ifa.load      = 1'b1;
            end
            tick();
            ifa.load = 1'b0;
            chk($sformatf("dis_an_%0d", k), 32'(ifa.an), 32'hF);
            chk($sformatf("dis_fd_%0d", k), 32'(ifa.frame_done), 32'd0);
        end
        ifa.enable = 1'b1;
        check_slots(tv[10], "reen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
